// File: rtl/serial_frame_rx_if.sv
// Receive-side bundle for serial_frame_rx: the serial line in, and the parallel
// valid/ready word plus the error and overrun pulses out.
interface serial_frame_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              din;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  // slave: the receiver itself; master: line driver plus word consumer.
  modport slave (
    input  din, dout_ready,
    output dout, dout_valid, parity_err, frame_err, overrun
  );

  modport master (
    output din, dout_ready,
    input  dout, dout_valid, parity_err, frame_err, overrun
  );
endinterface

// File: rtl/serial_frame_rx.sv
// One-bit-per-clock framed receiver (start, LSB-first data, optional even parity,
// stop) feeding a single-entry valid/ready output buffer.
module serial_frame_rx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 1
) (
  input logic              clk,
  input logic              rst_n,
  serial_frame_rx_if.slave bus
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic                parity_ok;

  assign parity_ok = (PARITY_EN == 0) || ((^shift_q) == par_q);

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  // NOTE: the shift register is a handful of flops, not a memory array, so it
  // is cleared on reset along with the rest of the datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_d        = par_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;

    if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (!bus.din) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        shift_d[cnt_q] = bus.din;
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        par_d   = bus.din;
        state_d = S_STOP;
      end
      S_STOP: begin
        if (bus.din) begin
          state_d = S_IDLE;
          if (!parity_ok) begin
            parity_err_d = 1'b1;
          end else if (!dout_valid_q || bus.dout_ready) begin
            // Empty buffer, or the old word leaves on this same edge.
            dout_d       = shift_q;
            dout_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (bus.din) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Single-bit serial frame receiver: deserializes a one-bit-per-clock framed stream (start bit, LSB-first data, optional even parity, stop bit) into parallel words. Completed words are presented through a one-entry valid/ready output buffer. Sits at the receiving end of a registered serial line driven by a flop-output transmitter in the same clock domain. No oversampling and no clock recovery.

## Interface
- `DATA_W`, default 8: data bits per frame; legal range 1–16.
- `PARITY_EN`, default 1: 1 inserts one even-parity bit between the data bits and the stop bit; 0 omits it.
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous reset, active-low; sampled on `posedge clk` only.
- `din` input 1: serial line, synchronous to `clk`, one bit per cycle; idle level is 1.
- `dout` output DATA_W: received word; bit 0 is the first data bit on the line.
- `dout_valid` output 1: `dout` holds an unconsumed word.
- `dout_ready` input 1: consumer accepts `dout` on any edge where `dout_valid & dout_ready`.
- `parity_err` output 1: one-cycle pulse; frame discarded on parity mismatch.
- `frame_err` output 1: one-cycle pulse; frame discarded because the stop bit was 0.
- `overrun` output 1: one-cycle pulse; a good frame was dropped because the buffer was full.

## Operation
- Reset (`rst_n`=0 at an edge):
  - state goes to IDLE;
  - `dout`=0, `dout_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0;
  - bit counter and shift register clear.
- Reset mid-frame abandons the frame with no error pulse.
- FSM states:
  - IDLE: `din`=0 sampled → DATA, bit count=0; otherwise stay.
  - DATA: shift `din` into bit position `count`; after bit DATA_W−1 → PARITY if PARITY_EN, else → STOP.
  - PARITY: capture the parity bit → STOP.
  - STOP:
    - `din`=1 and parity good (or PARITY_EN=0) → deliver the word, then IDLE.
    - `din`=1 and parity bad → `parity_err` pulse, discard the word, IDLE.
    - `din`=0 → `frame_err` pulse, discard the word, WAIT_HIGH.
  - WAIT_HIGH: stay until `din`=1 is sampled, then IDLE. The low line is never taken as a start bit.
- Parity check is even parity: XOR of the DATA_W data bits equals the parity bit.
- Delivering a word on the edge where the STOP state samples the stop bit:
  - `dout_valid`=0: load `dout`, set `dout_valid`.
  - `dout_valid`=1 and `dout_ready`=1 on the same edge: load the new word and keep `dout_valid`=1. No overrun.
  - `dout_valid`=1 and `dout_ready`=0: keep the old word, drop the new one, pulse `overrun`.
- `dout_valid` clears on an accept edge unless a new word loads on that same edge.
- `dout` is stable while `dout_valid`=1 and not accepted.
- Error pulses are mutually exclusive for a given frame.

## Timing
- Edge numbering: the start bit is sampled at edge 0.
  - Data bit k is sampled at edge 1+k.
  - Parity is sampled at edge DATA_W+1.
  - Stop is sampled at edge DATA_W+1+PARITY_EN.
- `dout_valid`, `dout` and the error/overrun pulses are registered. They become visible in the cycle after the stop edge: 11 edges after the start edge for the defaults.
- Back-to-back frames: a start bit on the cycle immediately after the stop bit is accepted. Minimum frame period is DATA_W+2+PARITY_EN cycles (11 by default).
- Each error/overrun pulse is high for exactly one cycle per event.
- A bit counter of ceil(log2(DATA_W)) bits is sufficient; the counter never wraps within a frame.

## Test plan
- Defaults, `dout_ready`=1; drive 1,0,{1,0,1,0,0,1,0,1},0,1 (word 0xA5, parity 0) → `dout`=0xA5 with a one-cycle `dout_valid` visible 11 edges after the start edge; no error pulses.
- Same frame but parity bit=1 → `parity_err` pulses once; `dout_valid` stays 0; a following valid 0x3C frame (parity 0) is received correctly.
- Frame 0x0F with stop bit=0, `din` held low 5 more cycles, then high, then frame 0x81 (parity 0) → `frame_err` pulses once; no word from the low period; 0x81 is received.
- `dout_ready`=0; send 0x11 then 0x22 back-to-back → `dout`=0x11 held, `overrun` pulses at the second stop. Raising `dout_ready` → 0x11 accepted once and `dout_valid` falls.
- `dout_valid`=1 with 0x55; assert `dout_ready` exactly on the stop edge of frame 0xAA → `dout`=0xAA, `dout_valid` stays 1, no `overrun`.
- `rst_n`=0 for one edge after data bit 4 of a frame, line then held high → all outputs 0, no error pulses, no stray word; the next full frame 0x5A is received correctly.
